// File: rtl/cmos_fifo_pkg.sv
// Shared types and helpers for the CMOS pixel FIFO.
// Holds the pixel width default, width helper and status bundle.
package cmos_fifo_pkg;

    localparam int CMOS_PIX_W = 27;

    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/cmos_sync_fifo_if.sv
// Write/read/status bundle between CMOS capture, the FIFO and DAQ packing.
// The master drives requests, and the slave returns data and status.
interface cmos_sync_fifo_if #(
    parameter int DATA_WIDTH = 27,
    parameter int CNT_WIDTH  = 10
);
    logic                  clear;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_WIDTH-1:0]  count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clear, wr_en, din, rd_en,
        input  dout, valid, full, empty, almost_full,
        input  almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clear, wr_en, din, rd_en,
        output dout, valid, full, empty, almost_full,
        output almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/cmos_fifo_ram.sv
// Simple dual-port single-clock RAM with a synchronous write and a registered read.
// The read is read-first, so a same-address write returns the old word.
module cmos_fifo_ram #(
    parameter int DW    = 27,
    parameter int DEPTH = 600,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)    r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/cmos_sync_fifo.sv
// Single-clock CMOS pixel FIFO with any depth, fill count, and sticky and threshold flags.
// Define CMOS_FIFO_FWFT_EN for first-word-fall-through output.
module cmos_sync_fifo
    import cmos_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = CMOS_PIX_W,
    parameter int DEPTH      = 600,
    parameter int AFULL_TH   = DEPTH - 8,
    parameter int AEMPTY_TH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    cmos_sync_fifo_if.slave   bus
);
    localparam int ADDR_WIDTH = clog2w(DEPTH);
    localparam int CNT_WIDTH  = clog2w(DEPTH + 1);
    localparam logic [CNT_WIDTH-1:0]  LP_DEPTH  = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0]  LP_AFULL  = CNT_WIDTH'(AFULL_TH);
    localparam logic [CNT_WIDTH-1:0]  LP_AEMPTY = CNT_WIDTH'(AEMPTY_TH);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST   = ADDR_WIDTH'(DEPTH - 1);
    localparam fifo_status_t ST_RST = '{
        full: 1'b0, empty: 1'b1, almost_full: 1'b0,
        almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0
    };

    fifo_status_t            r_st, w_st_nxt;
    logic [CNT_WIDTH-1:0]    r_count, w_count_nxt;
    logic [ADDR_WIDTH-1:0]   r_wr_ptr, r_rd_ptr;
    logic [DATA_WIDTH-1:0]   w_ram_rdata;
    logic                    w_rd_acc, w_wr_acc;
    logic                    w_ram_we, w_ram_re;
    logic                    w_nvalid, w_empty_nxt;

    cmos_fifo_ram #(
        .DW(DATA_WIDTH), .DEPTH(DEPTH), .AW(ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.din),
        .i_re    (w_ram_re),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

`ifdef CMOS_FIFO_FWFT_EN
    // Head word sits in r_dout, and the next one waits in the RAM read register.
    logic                  r_valid, r_pf;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [CNT_WIDTH-1:0]  r_mem_cnt;
    logic                  w_out_load, w_bypass;

    always_comb begin
        w_rd_acc    = bus.rd_en & r_valid;
        w_wr_acc    = bus.wr_en & (~r_st.full | w_rd_acc);
        w_out_load  = ~r_valid | w_rd_acc;
        w_bypass    = w_out_load & ~r_pf & (r_mem_cnt == '0) & w_wr_acc;
        w_ram_we    = w_wr_acc & ~w_bypass;
        w_ram_re    = (r_mem_cnt != '0) & (~r_pf | w_out_load);
        w_nvalid    = w_out_load ? (r_pf | w_bypass) : r_valid;
        w_empty_nxt = ~w_nvalid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_pf      <= 1'b0;
            r_mem_cnt <= '0;
            r_dout    <= '0;
        end else if (bus.clear) begin
            r_valid   <= 1'b0;
            r_pf      <= 1'b0;
            r_mem_cnt <= '0;
        end else begin
            r_valid   <= w_nvalid;
            r_mem_cnt <= r_mem_cnt + CNT_WIDTH'(w_ram_we)
                                   - CNT_WIDTH'(w_ram_re);
            if (w_ram_re)        r_pf <= 1'b1;
            else if (w_out_load) r_pf <= 1'b0;
            if (w_out_load & r_pf) r_dout <= w_ram_rdata;
            else if (w_bypass)     r_dout <= bus.din;
        end
    end

    assign bus.dout  = r_dout;
    assign bus.valid = r_valid;
`else
    logic r_valid;

    always_comb begin
        w_rd_acc    = bus.rd_en & ~r_st.empty;
        w_wr_acc    = bus.wr_en & (~r_st.full | w_rd_acc);
        w_ram_we    = w_wr_acc;
        w_ram_re    = w_rd_acc;
        w_nvalid    = w_rd_acc;
        w_empty_nxt = (w_count_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) r_valid <= 1'b0;
        else                     r_valid <= w_nvalid;
    end

    assign bus.dout  = w_ram_rdata;
    assign bus.valid = r_valid;
`endif

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_st_nxt              = r_st;
        w_st_nxt.full         = (w_count_nxt == LP_DEPTH);
        w_st_nxt.empty        = w_empty_nxt;
        w_st_nxt.almost_full  = (w_count_nxt >= LP_AFULL);
        w_st_nxt.almost_empty = (w_count_nxt <= LP_AEMPTY);
        w_st_nxt.overflow     = r_st.overflow | (bus.wr_en & ~w_wr_acc);
        w_st_nxt.underflow    = r_st.underflow | (bus.rd_en & r_st.empty);
    end

    // Pointers wrap by compare so any DEPTH works.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_st     <= ST_RST;
        end else begin
            if (w_ram_we)
                r_wr_ptr <= (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + 1'b1;
            if (w_ram_re)
                r_rd_ptr <= (r_rd_ptr == LP_LAST) ? '0 : r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_st    <= w_st_nxt;
        end
    end

    assign bus.count        = r_count;
    assign bus.full         = r_st.full;
    assign bus.empty        = r_st.empty;
    assign bus.almost_full  = r_st.almost_full;
    assign bus.almost_empty = r_st.almost_empty;
    assign bus.overflow     = r_st.overflow;
    assign bus.underflow    = r_st.underflow;
endmodule

// File: tb/tb_cmos_sync_fifo.sv
// Directed bench for cmos_sync_fifo at DEPTH=600.
// It follows the FWFT read timing when CMOS_FIFO_FWFT_EN is defined.
module tb_cmos_sync_fifo;
    localparam int DW = 27;
    localparam int DEPTH = 600;
    localparam int CW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    cmos_sync_fifo_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    cmos_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic we, input logic [DW-1:0] d,
                        input logic re, input logic clr);
        bus.wr_en = we;
        bus.din   = d;
        bus.rd_en = re;
        bus.clear = clr;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.clear = 1'b0;
    endtask

    // One pop, optionally with a write in the same cycle, checking the word.
    task automatic rd_chk(input string tag, input logic [DW-1:0] exp,
                          input logic we, input logic [DW-1:0] d);
`ifdef CMOS_FIFO_FWFT_EN
        chk1({tag, ".valid"}, bus.valid, 1'b1);
        chkw({tag, ".dout"}, 32'(bus.dout), 32'(exp));
        step(we, d, 1'b1, 1'b0);
`else
        step(we, d, 1'b1, 1'b0);
        chk1({tag, ".valid"}, bus.valid, 1'b1);
        chkw({tag, ".dout"}, 32'(bus.dout), 32'(exp));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.clear = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk1("rst.empty", bus.empty, 1'b1);
        chk1("rst.aempty", bus.almost_empty, 1'b1);
        chk1("rst.full", bus.full, 1'b0);
        chk1("rst.valid", bus.valid, 1'b0);
        chkw("rst.count", 32'(bus.count), 32'd0);
        chkw("rst.dout", 32'(bus.dout), 32'd0);
        chk1("rst.ovf", bus.overflow, 1'b0);

        // fill 0..599 and watch the almost_full threshold at 592
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0);
            if (i == 0) chk1("w1.empty", bus.empty, 1'b0);
            if (i == 590) chk1("af.591", bus.almost_full, 1'b0);
            if (i == 591) chk1("af.592", bus.almost_full, 1'b1);
            if (i == 8) chk1("ae.9", bus.almost_empty, 1'b0);
        end
        chk1("fill.full", bus.full, 1'b1);
        chkw("fill.count", 32'(bus.count), 32'd600);
        chk1("fill.ovf0", bus.overflow, 1'b0);
        step(1'b1, DW'(600), 1'b0, 1'b0);
        chk1("ovf.set", bus.overflow, 1'b1);
        chkw("ovf.count", 32'(bus.count), 32'd600);
        chk1("ovf.full", bus.full, 1'b1);

        // read 300, refill 300, drain all 600 across the pointer wrap
        for (int i = 0; i < 300; i++) rd_chk("drainA", DW'(i), 1'b0, '0);
        chkw("half.count", 32'(bus.count), 32'd300);
        chk1("half.full", bus.full, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, DW'(2000 + i), 1'b0, 1'b0);
        chkw("refill.count", 32'(bus.count), 32'd600);
        for (int i = 300; i < 600; i++) rd_chk("drainB", DW'(i), 1'b0, '0);
        for (int i = 0; i < 300; i++) rd_chk("drainC", DW'(2000 + i), 1'b0, '0);
        chk1("drain.empty", bus.empty, 1'b1);
        chkw("drain.count", 32'(bus.count), 32'd0);
        chk1("drain.af", bus.almost_full, 1'b0);
        chk1("drain.ovf", bus.overflow, 1'b1);

        // simultaneous write and read on a full FIFO
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(1000 + i), 1'b0, 1'b0);
        rd_chk("simf", DW'(1000), 1'b1, DW'(32'h5A5A5A5));
        chkw("simf.count", 32'(bus.count), 32'd600);
        chk1("simf.full", bus.full, 1'b1);
        for (int i = 1; i < DEPTH; i++) rd_chk("simfB", DW'(1000 + i), 1'b0, '0);
        rd_chk("simf.new", DW'(32'h5A5A5A5), 1'b0, '0);
        chk1("simf.empty", bus.empty, 1'b1);

        // underflow, clear, and simultaneous access on empty
        chk1("unf.pre", bus.underflow, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk1("unf.valid", bus.valid, 1'b0);
        chk1("unf.set", bus.underflow, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk1("clr.unf", bus.underflow, 1'b0);
        chk1("clr.ovf", bus.overflow, 1'b0);
        chkw("clr.count", 32'(bus.count), 32'd0);
        step(1'b1, DW'(32'h77), 1'b1, 1'b0);
        chkw("wre.count", 32'(bus.count), 32'd1);
        chk1("wre.unf", bus.underflow, 1'b1);
        chk1("wre.empty", bus.empty, 1'b0);
        rd_chk("wre.data", DW'(32'h77), 1'b0, '0);

        // clear with data present drops it and restarts the pointers
        for (int i = 0; i < 5; i++) step(1'b1, DW'(300 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chkw("clr2.count", 32'(bus.count), 32'd0);
        chk1("clr2.empty", bus.empty, 1'b1);
        chk1("clr2.valid", bus.valid, 1'b0);
        step(1'b1, DW'(32'h1234567), 1'b0, 1'b0);
`ifdef CMOS_FIFO_FWFT_EN
        chk1("fwft.valid", bus.valid, 1'b1);
        chkw("fwft.dout", 32'(bus.dout), 32'h1234567);
        step(1'b0, '0, 1'b1, 1'b0);
        chk1("fwft.pop.valid", bus.valid, 1'b0);
        chk1("fwft.pop.empty", bus.empty, 1'b1);
`else
        chk1("std.novalid", bus.valid, 1'b0);
        rd_chk("std.post", DW'(32'h1234567), 1'b0, '0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk1("std.hold.valid", bus.valid, 1'b0);
        chkw("std.hold.dout", 32'(bus.dout), 32'h1234567);
        chk1("std.empty", bus.empty, 1'b1);
`endif
        chkw("end.count", 32'(bus.count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
